// File: rtl/medidor_faixa_multi_pkg.sv
// Shared types and helpers for the multi-channel ultrasonic range meter.
package medidor_pkg;

  localparam int unsigned BcdW = 12;

  typedef enum logic [3:0] {
    StInicial    = 4'd0,
    StPrepara    = 4'd1,
    StTrigger    = 4'd2,
    StEsperaEcho = 4'd3,
    StMede       = 4'd4,
    StArmazena   = 4'd5,
    StGuarda     = 4'd6,
    StFim        = 4'd7
  } estado_e;

  // Packed BCD keeps numeric order, so a plain unsigned compare suffices.
  function automatic logic bcd_le(input logic [BcdW-1:0] a, input logic [BcdW-1:0] b);
    return a <= b;
  endfunction

  function automatic logic [BcdW-1:0] to_bcd(input int unsigned v);
    logic [3:0] c, d, u;
    c = 4'((v / 100) % 10);
    d = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {c, d, u};
  endfunction

endpackage

// File: rtl/medidor_faixa_multi_if.sv
// Sensor pins, limits and results of the range meter bundled as one port.
interface medidor_faixa_multi_if
  import medidor_pkg::*;
#(
  parameter int unsigned N_CH = 2
);
  logic                 medir;
  logic                 continuo;
  logic [BcdW*N_CH-1:0] lower;
  logic [BcdW*N_CH-1:0] upper;
  logic [N_CH-1:0]      echo;
  logic [N_CH-1:0]      trigger;
  logic [BcdW*N_CH-1:0] medida;
  logic [N_CH-1:0]      dentro;
  logic [N_CH-1:0]      timeout;
  logic                 pronto;
  logic                 ocupado;
  logic [3:0]           db_estado;

  modport master (
    output medir, continuo, lower, upper, echo,
    input  trigger, medida, dentro, timeout, pronto, ocupado, db_estado
  );

  modport slave (
    input  medir, continuo, lower, upper, echo,
    output trigger, medida, dentro, timeout, pronto, ocupado, db_estado
  );
endinterface

// File: rtl/medidor_faixa_multi_contador_bcd_cm.sv
// Converts echo-high clocks to centimetres: CmDiv prescaler feeding a 3-digit BCD counter.
module contador_bcd_cm
  import medidor_pkg::*;
#(
  parameter int unsigned CmDiv = 2941,
  parameter int unsigned MaxCm = 400
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [BcdW-1:0] bcd_o,
  output logic            max_o
);

  localparam int unsigned     PreW   = (CmDiv > 1) ? $clog2(CmDiv) : 1;
  localparam logic [PreW-1:0] PreEnd = PreW'(CmDiv - 1);
  localparam logic [BcdW-1:0] MaxBcd = to_bcd(MaxCm);

  logic [PreW-1:0] pre_q;
  logic [3:0]      d0_q, d1_q, d2_q;

  assign bcd_o = {d2_q, d1_q, d0_q};
  assign max_o = (bcd_o == MaxBcd);

  // Counting freezes at the maximum so a timeout reading is exactly MaxCm.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
    end else if (clr_i) begin
      pre_q <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
    end else if (en_i && !max_o) begin
      if (pre_q == PreEnd) begin
        pre_q <= '0;
        if (d0_q == 4'd9) begin
          d0_q <= '0;
          if (d1_q == 4'd9) begin
            d1_q <= '0;
            d2_q <= (d2_q == 4'd9) ? 4'd0 : d2_q + 4'd1;
          end else begin
            d1_q <= d1_q + 4'd1;
          end
        end else begin
          d0_q <= d0_q + 4'd1;
        end
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/medidor_faixa_multi.sv
// Round-robin ultrasonic range meter: triggers each sensor in turn, measures the echo in cm
// (BCD) and flags per channel whether the reading lies inside its [lower, upper] window.
module medidor_faixa_multi
  import medidor_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned TRIG_CYC  = 500,
  parameter int unsigned CM_DIV    = 2941,
  parameter int unsigned MAX_CM    = 400,
  parameter int unsigned WAIT_CYC  = 1_500_000,
  parameter int unsigned GUARD_CYC = 500_000
) (
  input logic                  clock,
  input logic                  reset_n,
  medidor_faixa_multi_if.slave bus
);

  localparam int unsigned ChW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CntMax = (WAIT_CYC > GUARD_CYC)
                                   ? ((WAIT_CYC > TRIG_CYC) ? WAIT_CYC : TRIG_CYC)
                                   : ((GUARD_CYC > TRIG_CYC) ? GUARD_CYC : TRIG_CYC);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] TrigEnd  = CntW'(TRIG_CYC - 1);
  localparam logic [CntW-1:0] WaitEnd  = CntW'(WAIT_CYC - 1);
  localparam logic [CntW-1:0] GuardEnd = CntW'(GUARD_CYC - 1);
  localparam logic [ChW-1:0]  LastCh   = ChW'(N_CH - 1);

  estado_e                   state_q;
  logic [ChW-1:0]            ch_q;
  logic [CntW-1:0]           cnt_q;
  logic [N_CH-1:0]           trigger_q;
  logic                      baixo_q;
  logic                      tmo_q;
  logic [N_CH-1:0][BcdW-1:0] medida_q;
  logic [N_CH-1:0]           dentro_q;
  logic [N_CH-1:0]           timeout_q;

  logic [N_CH-1:0] echo_s1_q, echo_s2_q;
  logic            medir_q, inicio_q;

  logic [N_CH-1:0][BcdW-1:0] lower_v, upper_v;
  logic [N_CH-1:0]           ch_mask;
  logic                      echo_ch;
  logic [BcdW-1:0]           cm_bcd;
  logic                      cm_max;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
      medir_q   <= 1'b0;
      inicio_q  <= 1'b0;
    end else begin
      echo_s1_q <= bus.echo;
      echo_s2_q <= echo_s1_q;
      medir_q   <= bus.medir;
      inicio_q  <= bus.medir & ~medir_q;
    end
  end

  assign lower_v = bus.lower;
  assign upper_v = bus.upper;
  assign echo_ch = echo_s2_q[ch_q];

  always_comb begin
    ch_mask       = '0;
    ch_mask[ch_q] = 1'b1;
  end

  contador_bcd_cm #(
    .CmDiv (CM_DIV),
    .MaxCm (MAX_CM)
  ) u_contador (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .clr_i  (state_q == StPrepara),
    .en_i   (state_q == StMede),
    .bcd_o  (cm_bcd),
    .max_o  (cm_max)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StInicial;
      ch_q      <= '0;
      cnt_q     <= '0;
      trigger_q <= '0;
      baixo_q   <= 1'b0;
      tmo_q     <= 1'b0;
      medida_q  <= '0;
      dentro_q  <= '0;
      timeout_q <= '0;
    end else begin
      unique case (state_q)
        StInicial: begin
          ch_q <= '0;
          if (inicio_q) state_q <= StPrepara;
        end
        StPrepara: begin
          cnt_q     <= '0;
          baixo_q   <= 1'b0;
          tmo_q     <= 1'b0;
          trigger_q <= ch_mask;
          state_q   <= StTrigger;
        end
        StTrigger: begin
          baixo_q <= baixo_q | ~echo_ch;
          if (cnt_q == TrigEnd) begin
            cnt_q     <= '0;
            trigger_q <= '0;
            state_q   <= StEsperaEcho;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEsperaEcho: begin
          // An echo already high when the trigger started must be seen low first.
          if (echo_ch && baixo_q) begin
            state_q <= StMede;
          end else begin
            baixo_q <= baixo_q | ~echo_ch;
            if (cnt_q == WaitEnd) begin
              tmo_q   <= 1'b1;
              state_q <= StArmazena;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StMede: begin
          if (cm_max) begin
            tmo_q   <= 1'b1;
            state_q <= StArmazena;
          end else if (!echo_ch) begin
            state_q <= StArmazena;
          end
        end
        StArmazena: begin
          // Counter holds 000 if the echo never rose and MAX_CM if it saturated.
          medida_q[ch_q]  <= cm_bcd;
          timeout_q[ch_q] <= tmo_q;
          dentro_q[ch_q]  <= !tmo_q && bcd_le(lower_v[ch_q], cm_bcd)
                             && bcd_le(cm_bcd, upper_v[ch_q]);
          cnt_q           <= '0;
          state_q         <= StGuarda;
        end
        StGuarda: begin
          if (cnt_q == GuardEnd) begin
            cnt_q <= '0;
            if (ch_q == LastCh) begin
              state_q <= StFim;
            end else begin
              ch_q    <= ch_q + 1'b1;
              state_q <= StPrepara;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFim: begin
          ch_q    <= '0;
          state_q <= bus.continuo ? StPrepara : StInicial;
        end
        default: state_q <= StInicial;
      endcase
    end
  end

  assign bus.trigger   = trigger_q;
  assign bus.medida    = medida_q;
  assign bus.dentro    = dentro_q;
  assign bus.timeout   = timeout_q;
  assign bus.pronto    = (state_q == StFim);
  assign bus.ocupado   = (state_q != StInicial);
  assign bus.db_estado = state_q;

endmodule

// File: tb/tb_medidor_faixa_multi.sv
// Directed bench for medidor_faixa_multi with a small echo responder per sensor.
module tb_medidor_faixa_multi;

  logic clk = 1'b0;
  logic rst_n;
  logic echo0 = 1'b0;
  logic echo1 = 1'b0;
  int   len0 = 0;
  int   len1 = 0;
  int   n_checks = 0;
  int   n_erros = 0;
  int   pronto_cnt = 0;
  int   trig0_cnt = 0;

  medidor_faixa_multi_if #(.N_CH(2)) bus ();

  assign bus.echo = {echo1, echo0};

  medidor_faixa_multi #(
    .N_CH      (2),
    .TRIG_CYC  (3),
    .CM_DIV    (4),
    .MAX_CM    (20),
    .WAIT_CYC  (50),
    .GUARD_CYC (5)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.pronto) pronto_cnt++;
    if (bus.trigger[0]) trig0_cnt++;
  end

  // Sensor model: echo rises two clocks after trigger ends and stays high len clocks.
  always @(negedge bus.trigger[0]) begin
    if (len0 > 0) begin
      repeat (2) @(posedge clk);
      #1 echo0 = 1'b1;
      repeat (len0) @(posedge clk);
      #1 echo0 = 1'b0;
    end
  end

  always @(negedge bus.trigger[1]) begin
    if (len1 > 0) begin
      repeat (2) @(posedge clk);
      #1 echo1 = 1'b1;
      repeat (len1) @(posedge clk);
      #1 echo1 = 1'b0;
    end
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  task automatic pulsa_medir();
    @(negedge clk) bus.medir = 1'b1;
    repeat (2) @(negedge clk);
    bus.medir = 1'b0;
  endtask

  task automatic varre(output int npr);
    int p0;
    int n;
    p0 = pronto_cnt;
    n  = 0;
    pulsa_medir();
    while (pronto_cnt == p0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1 npr = pronto_cnt - p0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int npr;
    int t0;
    int p0;
    int n;
    rst_n        = 1'b0;
    bus.medir    = 1'b0;
    bus.continuo = 1'b0;
    bus.lower    = {12'h005, 12'h005};
    bus.upper    = {12'h015, 12'h015};
    len0         = 48;
    len1         = 30;

    repeat (3) @(negedge clk);
    verifica("rst_trigger", bus.trigger, 2'b00);
    verifica("rst_medida", bus.medida, 24'h0);
    verifica("rst_dentro", bus.dentro, 2'b00);
    verifica("rst_timeout", bus.timeout, 2'b00);
    verifica("rst_pronto", bus.pronto, 1'b0);
    verifica("rst_ocupado", bus.ocupado, 1'b0);
    verifica("rst_estado", bus.db_estado, 4'd0);
    @(negedge clk) rst_n = 1'b1;

    // Nominal sweep: 48 clk -> 12 cm, 30 clk -> 7 cm (truncated)
    t0 = trig0_cnt;
    varre(npr);
    verifica("s1_pronto", npr, 1);
    verifica("s1_trig_len", trig0_cnt - t0, 3);
    verifica("s1_medida0", bus.medida[11:0], 12'h012);
    verifica("s1_medida1", bus.medida[23:12], 12'h007);
    verifica("s1_dentro", bus.dentro, 2'b11);
    verifica("s1_timeout", bus.timeout, 2'b00);
    verifica("s1_ocupado", bus.ocupado, 1'b0);
    verifica("s1_estado", bus.db_estado, 4'd0);

    // Echo0 too long saturates at MAX_CM
    len0 = 100;
    varre(npr);
    verifica("s2_pronto", npr, 1);
    verifica("s2_medida0", bus.medida[11:0], 12'h020);
    verifica("s2_timeout", bus.timeout, 2'b01);
    verifica("s2_dentro", bus.dentro, 2'b10);
    verifica("s2_medida1", bus.medida[23:12], 12'h007);

    // Echo1 never rises
    len0 = 48;
    len1 = 0;
    varre(npr);
    verifica("s3_pronto", npr, 1);
    verifica("s3_medida1", bus.medida[23:12], 12'h000);
    verifica("s3_timeout", bus.timeout, 2'b10);
    verifica("s3_dentro", bus.dentro, 2'b01);
    verifica("s3_medida0", bus.medida[11:0], 12'h012);

    // Window edges: 5 cm at lower=005, 15 cm at upper=015
    len0 = 20;
    len1 = 60;
    varre(npr);
    verifica("s4_medida0", bus.medida[11:0], 12'h005);
    verifica("s4_medida1", bus.medida[23:12], 12'h015);
    verifica("s4_dentro", bus.dentro, 2'b11);
    verifica("s4_timeout", bus.timeout, 2'b00);

    // ch0 just below lower=006, ch1 with lower > upper
    bus.lower = {12'h016, 12'h006};
    bus.upper = {12'h015, 12'h015};
    varre(npr);
    verifica("s5_medida1", bus.medida[23:12], 12'h015);
    verifica("s5_dentro", bus.dentro, 2'b00);

    // Continuous mode, cleared part-way through the third sweep
    bus.lower    = {12'h005, 12'h005};
    bus.upper    = {12'h015, 12'h015};
    bus.continuo = 1'b1;
    p0 = pronto_cnt;
    t0 = trig0_cnt;
    n  = 0;
    pulsa_medir();
    while (pronto_cnt < p0 + 2 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    verifica("cont_ocupado_mid", bus.ocupado, 1'b1);
    bus.continuo = 1'b0;
    repeat (600) @(negedge clk);
    verifica("cont_pronto", pronto_cnt - p0, 3);
    verifica("cont_trig0", trig0_cnt - t0, 9);
    verifica("cont_estado", bus.db_estado, 4'd0);
    verifica("cont_dentro", bus.dentro, 2'b11);

    // Reset in the middle of a measurement
    len0 = 48;
    len1 = 30;
    pulsa_medir();
    n = 0;
    while (bus.db_estado != 4'd4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    verifica("rst_in_mede", bus.db_estado, 4'd4);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    verifica("mrst_trigger", bus.trigger, 2'b00);
    verifica("mrst_medida", bus.medida, 24'h0);
    verifica("mrst_dentro", bus.dentro, 2'b00);
    verifica("mrst_timeout", bus.timeout, 2'b00);
    verifica("mrst_ocupado", bus.ocupado, 1'b0);
    verifica("mrst_estado", bus.db_estado, 4'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (80) @(negedge clk);

    varre(npr);
    verifica("post_pronto", npr, 1);
    verifica("post_medida0", bus.medida[11:0], 12'h012);
    verifica("post_medida1", bus.medida[23:12], 12'h007);
    verifica("post_dentro", bus.dentro, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule

// File: doc/medidor_faixa_multi.md
# medidor_faixa_multi

Multi-channel successor of the single-sensor range meter: drives N ultrasonic sensors in round-robin, measures each echo width in centimetres as 3-digit BCD, and flags per channel whether the reading lies inside a per-channel window [lower, upper]. Supports single-sweep and continuous modes, echo timeout and an inter-channel guard gap against crosstalk. It sits between the sensor pins and the display/serial logic, replacing the fixed-limit single-channel meter.

## Interface
- N_CH, 2: number of sensor channels (1..8)
- TRIG_CYC, 500: trigger pulse width in clocks (10 us @ 50 MHz)
- CM_DIV, 2941: clocks of echo-high per centimetre
- MAX_CM, 400: max range in cm; echo reaching this is a timeout
- WAIT_CYC, 1_500_000: max clocks from trigger end to echo rise
- GUARD_CYC, 500_000: idle clocks between channels

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- medir  in  1  start one sweep (sampled on rising edge of the level)
- continuo  in  1  1 = restart sweeps back-to-back until cleared
- lower  in  12*N_CH  per-channel lower limit, BCD, channel i at [12i+11:12i]
- upper  in  12*N_CH  per-channel upper limit, BCD
- echo  in  N_CH  sensor echo lines, asynchronous
- trigger  out  N_CH  sensor trigger lines
- medida  out  12*N_CH  last measurement per channel, BCD
- dentro  out  N_CH  lower <= medida <= upper and not timeout
- timeout  out  N_CH  last measurement of channel timed out
- pronto  out  1  one-cycle pulse at end of each sweep
- ocupado  out  1  sweep in progress
- db_estado  out  4  current FSM state code

## Operation
- echo passes a 2-flop synchroniser; all decisions use the synchronised copy.
- FSM: INICIAL -> PREPARA -> TRIGGER -> ESPERA_ECHO -> MEDE -> ARMAZENA -> GUARDA -> (PREPARA for next channel | FIM) ; FIM -> PREPARA if continuo else INICIAL.
- INICIAL: wait for medir rising edge; channel index = 0.
- PREPARA: clear cycle and BCD counters, 1 cycle.
- TRIGGER: trigger[ch] = 1 for exactly TRIG_CYC cycles; other triggers 0.
- ESPERA_ECHO: on echo_sync[ch] = 1 -> MEDE; after WAIT_CYC cycles -> ARMAZENA with timeout.
- MEDE: prescaler counts clocks; every CM_DIV clocks the BCD counter increments (digit wrap 9->0 with carry). echo fall -> ARMAZENA. BCD value reaching MAX_CM -> ARMAZENA with timeout.
- ARMAZENA: medida[ch] <= counter (MAX_CM in BCD on timeout, 000 if echo never rose); timeout[ch], dentro[ch] updated together. Partial centimetre discarded (truncation).
- GUARDA: idle GUARD_CYC cycles; last channel -> FIM, else ch+1 -> PREPARA.
- FIM: pronto = 1 for one cycle.
- Comparison is unsigned on the 12-bit BCD word (BCD order equals numeric order). lower > upper -> dentro always 0.
- medir while ocupado is ignored. Clearing continuo mid-sweep finishes the current sweep, then returns to INICIAL.
- Limits are sampled in ARMAZENA, so they may change at any time.

## Timing
- Reset (async assert, sync-released): state INICIAL, trigger = 0, medida = 000, dentro = 0, timeout = 0, pronto = 0, ocupado = 0, db_estado = 0.
- medir edge to trigger[0] high: 3 cycles (edge detect, INICIAL->PREPARA, PREPARA->TRIGGER).
- Echo fall at pin to ARMAZENA: 3 cycles (2 sync + 1); outputs valid the following cycle.
- Outputs of a channel change only in its ARMAZENA cycle; other channels hold.
- ocupado = 1 from PREPARA through FIM inclusive.
- reset_n asserted mid-measurement: trigger drops immediately, all stored results cleared.
- Echo already high at TRIGGER entry: counted only after it is seen low then high (rise required).

## Structure
- Package medidor_pkg: state enum with fixed codes (INICIAL=0 ... FIM=7), BCD width constant (12), and the bcd_le helper function.
- One sub-module: contador_bcd_cm (CM_DIV prescaler + 3-digit BCD counter with clear, enable, and max-reached flag).
- Top contains synchronisers, FSM, channel index, trigger/timeout counters and per-channel result registers.

## Test plan
- Sim params N_CH=2, TRIG_CYC=3, CM_DIV=4, MAX_CM=20, WAIT_CYC=50, GUARD_CYC=5.
- Echo0 high 48 clocks, echo1 high 30 clocks, limits 005..015 -> medida0 = 012, dentro0 = 1; medida1 = 007, dentro1 = 1; single pronto pulse; ocupado returns to 0.
- Echo0 high 100 clocks -> medida0 = 020, timeout0 = 1, dentro0 = 0; channel 1 still measured.
- Echo1 never rises -> after 50 cycles medida1 = 000, timeout1 = 1, sweep continues to FIM.
- continuo = 1 with echoes fixed -> repeated pronto pulses, GUARD_CYC gap between trigger pulses; clear continuo mid-sweep -> exactly one more pronto, then INICIAL.
- Boundary: medida = 005 with lower = 005, and medida = 015 with upper = 015 -> dentro = 1; lower = 016, upper = 015 -> dentro = 0.
- reset_n pulsed low during MEDE -> trigger = 0, all outputs 0 asynchronously; next medir sweeps normally.
